// File: rtl/arb2_req_queue.sv
// Two client FIFOs feeding a two-way arbiter; granted head words are
// dispatched one per cycle with a registered output and a sticky error flag.
module arb2_req_queue #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in1_valid,
    input  logic [DW-1:0] in1_data,
    output logic          in1_ready,
    input  logic          in2_valid,
    input  logic [DW-1:0] in2_data,
    output logic          in2_ready,
    output logic          req1,
    output logic          req2,
    input  logic          gnt1,
    input  logic          gnt2,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_src,
    output logic          err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem2 [DEPTH];
    logic [AW-1:0] wptr1, rptr1, wptr2, rptr2;
    logic [CW-1:0] cnt1, cnt2;
    logic          push1, push2, pop1, pop2;

    assign in1_ready = (cnt1 < CW'(DEPTH)) && !rst;
    assign in2_ready = (cnt2 < CW'(DEPTH)) && !rst;
    assign req1      = (cnt1 != '0);
    assign req2      = (cnt2 != '0);
    assign push1     = in1_valid && in1_ready;
    assign push2     = in2_valid && in2_ready;
    // Client 1 wins a double grant; client 2 pops only on a clean grant.
    assign pop1      = gnt1 && req1;
    assign pop2      = gnt2 && req2 && !gnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr1 <= '0;
            rptr1 <= '0;
            cnt1  <= '0;
            wptr2 <= '0;
            rptr2 <= '0;
            cnt2  <= '0;
        end else begin
            if (push1) wptr1 <= wptr1 + AW'(1);
            if (pop1)  rptr1 <= rptr1 + AW'(1);
            if (push1 && !pop1)      cnt1 <= cnt1 + CW'(1);
            else if (pop1 && !push1) cnt1 <= cnt1 - CW'(1);
            if (push2) wptr2 <= wptr2 + AW'(1);
            if (pop2)  rptr2 <= rptr2 + AW'(1);
            if (push2 && !pop2)      cnt2 <= cnt2 + CW'(1);
            else if (pop2 && !push2) cnt2 <= cnt2 - CW'(1);
        end
    end

    // Storage is unreset; pushes are already blocked during reset via ready.
    always_ff @(posedge clk) begin
        if (push1) mem1[wptr1] <= in1_data;
        if (push2) mem2[wptr2] <= in2_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else if (pop1) begin
            out_valid <= 1'b1;
            out_data  <= mem1[rptr1];
            out_src   <= 1'b0;
        end else if (pop2) begin
            out_valid <= 1'b1;
            out_data  <= mem2[rptr2];
            out_src   <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)               err <= 1'b0;
        else if (gnt1 && gnt2) err <= 1'b1;
    end
endmodule

// File: tb/tb_arb2_req_queue.sv
// Scoreboard bench for arb2_req_queue: queue-based reference model predicts
// each cycle's output; a separate monitor compares after every rising edge.
module tb_arb2_req_queue;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in1_valid, in2_valid, gnt1, gnt2;
    logic [DW-1:0] in1_data, in2_data;
    logic          in1_ready, in2_ready, req1, req2;
    logic          out_valid, out_src, err;
    logic [DW-1:0] out_data;

    arb2_req_queue #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .in2_valid(in2_valid), .in2_data(in2_data), .in2_ready(in2_ready),
        .req1(req1), .req2(req2), .gnt1(gnt1), .gnt2(gnt2),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
        logic          s;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    logic          m_err;
    logic [DW-1:0] m_data;
    logic          m_src;
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, check level outputs against the model, then advance the model at the edge.
    task automatic step(input logic v1, input logic [DW-1:0] d1, input logic v2,
                        input logic [DW-1:0] d2, input logic g1, input logic g2,
                        input logic r);
        logic   rdy1, rdy2, p1, p2, o1, o2;
        exp_t   e;
        @(negedge clk);
        rst = r; in1_valid = v1; in1_data = d1; in2_valid = v2; in2_data = d2;
        gnt1 = g1; gnt2 = g2;
        #1;
        rdy1 = !r && (q1.size() < DEPTH);
        rdy2 = !r && (q2.size() < DEPTH);
        chk("in1_ready", 32'(in1_ready), 32'(rdy1));
        chk("in2_ready", 32'(in2_ready), 32'(rdy2));
        chk("req1", 32'(req1), 32'(q1.size() > 0));
        chk("req2", 32'(req2), 32'(q2.size() > 0));
        chk("err", 32'(err), 32'(m_err));
        p1 = v1 && rdy1;
        p2 = v2 && rdy2;
        o1 = !r && g1 && (q1.size() > 0);
        o2 = !r && g2 && !g1 && (q2.size() > 0);
        @(posedge clk);
        e.v = 1'b0;
        if (r) begin
            q1.delete(); q2.delete();
            m_err = 1'b0; m_data = '0; m_src = 1'b0;
        end else begin
            if (o1) begin
                m_data = q1.pop_front(); m_src = 1'b0; e.v = 1'b1;
            end else if (o2) begin
                m_data = q2.pop_front(); m_src = 1'b1; e.v = 1'b1;
            end
            if (p1) q1.push_back(d1);
            if (p2) q2.push_back(d2);
            if (g1 && g2) m_err = 1'b1;
        end
        e.d = m_data;
        e.s = m_src;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares each registered output against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_valid", 32'(out_valid), 32'(e.v));
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("out_src", 32'(out_src), 32'(e.s));
            end
        end
    end

    initial begin
        rst = 1'b1; in1_valid = 1'b0; in2_valid = 1'b0; gnt1 = 1'b0; gnt2 = 1'b0;
        in1_data = '0; in2_data = '0;
        m_err = 1'b0; m_data = '0; m_src = 1'b0;
        @(posedge clk);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 8'h99, 1'b1, 8'h98, 1'b0, 1'b0, 1'b1);

        // Two words on client 1, then drain with back-to-back grants.
        step(1'b1, 8'h11, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Fill client 2, offer a fifth word while full, then free one slot.
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Double grant with both FIFOs holding words.
        step(1'b1, 8'h33, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Clear err, then grant an empty client 1; push+grant on empty must not pop.
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Reset mid-operation discards queued words.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);

        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 4),
                 1'($urandom_range(0, 79) == 0));
        end
        idle(2);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arb2_req_queue.md
ARB2_REQ_QUEUE -- requirements
Module: arb2_req_queue

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data word width in bits (DW >= 1).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning entries per client FIFO (power of two, DEPTH >= 2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in1_valid  input  1  client 1 offers a word.
REQ-006 in1_data  input  DW  client 1 word.
REQ-007 in1_ready  output  1  FIFO1 accepts a word this cycle.
REQ-008 in2_valid  input  1  client 2 offers a word.
REQ-009 in2_data  input  DW  client 2 word.
REQ-010 in2_ready  output  1  FIFO2 accepts a word this cycle.
REQ-011 req1  output  1  request to the two-way arbiter for client 1.
REQ-012 req2  output  1  request to the two-way arbiter for client 2.
REQ-013 gnt1  input  1  grant from the arbiter for client 1.
REQ-014 gnt2  input  1  grant from the arbiter for client 2.
REQ-015 out_valid  output  1  out_data/out_src hold a dispatched word this cycle.
REQ-016 out_data  output  DW  dispatched word.
REQ-017 out_src  output  1  origin of out_data: 0 = client 1, 1 = client 2.
REQ-018 err  output  1  sticky protocol-error flag.

Function
REQ-019 Each client SHALL own an independent DEPTH-entry FIFO with read/write pointers and an occupancy count of $clog2(DEPTH)+1 bits; pointers wrap from DEPTH-1 to 0.
REQ-020 inN_ready SHALL be 1 exactly when FIFO N count < DEPTH and rst = 0.
REQ-021 A push into FIFO N SHALL occur on a rising edge where inN_valid = 1 and inN_ready = 1; inN_data is written at the write pointer.
REQ-022 reqN SHALL be 1 exactly when FIFO N count > 0 (decoded from registered count, no combinational path from any input).
REQ-023 A pop of FIFO N SHALL occur on a rising edge where gntN = 1 and reqN = 1 (grant qualified by the current request).
REQ-024 gntN while reqN = 0 SHALL be ignored: no pop, no output change beyond REQ-026, err unaffected.
REQ-025 On a pop, the head word SHALL be registered: next cycle out_valid = 1, out_data = head word, out_src = N-1 (latency exactly one cycle from grant edge).
REQ-026 On any edge with no pop, out_valid SHALL go to 0; out_data and out_src SHALL hold their last values.
REQ-027 gnt1 = 1 and gnt2 = 1 on the same edge SHALL pop FIFO1 only (if req1 = 1), leave FIFO2 unchanged, and set err = 1.
REQ-028 gntN = 1 for a client whose reqN = 0 while the other grant is 0 SHALL NOT set err.
REQ-029 Simultaneous push and pop on the same FIFO SHALL leave count unchanged and advance both pointers; pushing into an empty FIFO and granting it on the same edge SHALL NOT pop (req was 0).
REQ-030 A push when full SHALL be impossible by REQ-020; inN_valid with inN_ready = 0 SHALL leave the FIFO unchanged.
REQ-031 Words from one client SHALL be dispatched in push order; no word is lost or duplicated.
REQ-032 err, once set, SHALL remain 1 until reset.

Reset
REQ-033 While rst = 1 at a rising edge: both FIFO counts and pointers = 0, out_valid = 0, out_data = 0, out_src = 0, err = 0.
REQ-034 While rst = 1: in1_ready = in2_ready = 0, req1 = req2 = 0 (after the first reset edge); pushes and grants ignored.
REQ-035 Reset asserted mid-operation SHALL discard all queued words; after release both FIFOs are empty and no stale word is dispatched.
REQ-036 FIFO storage array SHALL NOT require reset.

Verification
REQ-037 Push 0x11, 0x22 on client 1, no grants -> req1 = 1, req2 = 0, count1 = 2, out_valid = 0.
REQ-038 With 0x11, 0x22 queued, gnt1 on two consecutive edges -> out_valid = 1 with out_data 0x11 then 0x22, out_src = 0, then req1 = 0 and out_valid = 0.
REQ-039 Push 4 words on client 2 with DEPTH = 4 -> in2_ready = 0 after 4th push; 5th offer (in2_valid = 1) ignored; one gnt2 -> in2_ready = 1 next cycle.
REQ-040 Both FIFOs non-empty, gnt1 = gnt2 = 1 for one edge -> only client 1 head dispatched (out_src = 0), count2 unchanged, err = 1 and stays 1.
REQ-041 gnt1 = 1 with FIFO1 empty and gnt2 = 0 -> no dispatch, err = 0.
REQ-042 Three words queued on client 1, rst for one edge -> counts 0, req1 = 0, out_valid = 0; subsequent gnt1 produces no dispatch.
